// File: rtl/btn_event_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// btn_event_ctrl_pkg
//
// Purpose : Shared definitions for the player-button event path.
//           Holds the FSM state encoding (also exported on oState for debug),
//           the default cycle counts for a 100 MHz system clock, and a small
//           helper used when sizing counters.
//
// Contents:
//   STATE_W               width of the state encoding / oState
//   state_e               IDLE=0, PRESS_DB=1, HELD=2, LONG=3, RELEASE_DB=4
//   DEF_DEBOUNCE_CYCLES   10 ms debounce window at 100 MHz
//   DEF_LONG_CYCLES       1 s long-press threshold at 100 MHz
//   DEF_COOLDOWN_CYCLES   50 ms minimum spacing between flap events
//   max_int()             larger of two integers
// -----------------------------------------------------------------------------
package btn_event_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        HELD       = 3'd2,
        LONG       = 3'd3,
        RELEASE_DB = 3'd4
    } state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_LONG_CYCLES     = 100_000_000;
    localparam int DEF_COOLDOWN_CYCLES = 5_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_event_ctrl_if.sv
// -----------------------------------------------------------------------------
// btn_event_ctrl_if
//
// Purpose : Bundles the button input, the game enable and the event pulses
//           exchanged between the board/game side and btn_event_ctrl.
//
// Signals :
//   iBtn      raw asynchronous button level, active high
//   iEnable   game accepts flap events when 1
//   oPress    one-cycle pulse: debounced press accepted and emitted
//   oLong     one-cycle pulse: press held for the long threshold
//   oRelease  one-cycle pulse: debounced release
//   oDrop     one-cycle pulse: debounced press suppressed
//   oState    current FSM state encoding, debug only
//
// Modports:
//   master    board/game side: drives iBtn/iEnable, observes events
//   slave     btn_event_ctrl: consumes iBtn/iEnable, drives events
// -----------------------------------------------------------------------------
interface btn_event_ctrl_if;
    import btn_event_ctrl_pkg::*;

    logic               iBtn;
    logic               iEnable;
    logic               oPress;
    logic               oLong;
    logic               oRelease;
    logic               oDrop;
    logic [STATE_W-1:0] oState;

    modport master (
        output iBtn,
        output iEnable,
        input  oPress,
        input  oLong,
        input  oRelease,
        input  oDrop,
        input  oState
    );

    modport slave (
        input  iBtn,
        input  iEnable,
        output oPress,
        output oLong,
        output oRelease,
        output oDrop,
        output oState
    );

endinterface

// File: rtl/btn_event_ctrl_sync.sv
// -----------------------------------------------------------------------------
// btn_sync
//
// Purpose : Two-flop synchroniser for a slow asynchronous board input.
//           Reusable for any single-bit level input (buttons, switches).
//
// Ports   :
//   iClk    system clock
//   iRst_n  synchronous active-low reset, clears both flops
//   iSig    asynchronous input level
//   oSig    synchronised level, two iClk edges behind iSig
// -----------------------------------------------------------------------------
module btn_sync (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iSig,
    output logic oSig
);

    logic r_sync_p0;
    logic r_sync_p1;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
        end else begin
            // stage 0 may go metastable; stage 1 gives it a full cycle to settle
            r_sync_p0 <= iSig;
            r_sync_p1 <= r_sync_p0;
        end
    end

    assign oSig = r_sync_p1;

endmodule

// File: rtl/btn_event_ctrl.sv
// -----------------------------------------------------------------------------
// btn_event_ctrl
//
// Purpose : Player-button path for the game. Synchronises the raw button,
//           debounces press and release, and turns clean edges into
//           single-cycle events: flap (oPress), long-press (oLong) and
//           release (oRelease). Presses arriving while the cooldown is
//           running or while the game has disabled input are reported on
//           oDrop instead of oPress.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable-level cycles to accept a press/release (>= 2)
//   LONG_CYCLES      held cycles after an accepted press before oLong
//                    (> DEBOUNCE_CYCLES)
//   COOLDOWN_CYCLES  minimum spacing between oPress pulses; 0 disables it
//
// Ports   :
//   iClk    system clock
//   iRst_n  synchronous active-low reset
//   bus     btn_event_ctrl_if.slave: iBtn, iEnable in; oPress, oLong,
//           oRelease, oDrop, oState out (all outputs registered)
// -----------------------------------------------------------------------------
module btn_event_ctrl
    import btn_event_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
    input  logic              iClk,
    input  logic              iRst_n,
    btn_event_ctrl_if.slave   bus
);

    localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, LONG_CYCLES) + 1);
    // A zero cooldown still needs a 1-bit register that simply never loads.
    localparam int CD_W  = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CD_W-1:0]  CD_LOAD   = CD_W'(COOLDOWN_CYCLES);

    logic             w_btn_s;
    logic             w_accept_ok;

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CD_W-1:0]  r_cooldown;
    logic             r_press;
    logic             r_long;
    logic             r_release;
    logic             r_drop;

    btn_sync u_btn_sync (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iSig   (bus.iBtn),
        .oSig   (w_btn_s)
    );

    // iEnable only matters in the cycle a press is accepted.
    assign w_accept_ok = (r_cooldown == '0) && bus.iEnable;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_cooldown <= '0;
            r_press    <= 1'b0;
            r_long     <= 1'b0;
            r_release  <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_long    <= 1'b0;
            r_release <= 1'b0;
            r_drop    <= 1'b0;

            // Free-running countdown; a press accept below overrides it.
            if (r_cooldown != '0) begin
                r_cooldown <= r_cooldown - 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_btn_s) begin
                        r_state <= PRESS_DB;
                        r_cnt   <= '0;
                    end
                end

                PRESS_DB: begin
                    // A low sample always aborts, even on the threshold cycle.
                    if (!w_btn_s) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                        if (w_accept_ok) begin
                            r_press    <= 1'b1;
                            r_cooldown <= CD_LOAD;
                        end else begin
                            r_drop     <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                HELD: begin
                    // Release takes priority over reaching the long threshold.
                    if (!w_btn_s) begin
                        r_state <= RELEASE_DB;
                        r_cnt   <= '0;
                    end else if (r_cnt == LONG_LAST) begin
                        r_state <= LONG;
                        r_cnt   <= '0;
                        r_long  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                LONG: begin
                    if (!w_btn_s) begin
                        r_state <= RELEASE_DB;
                        r_cnt   <= '0;
                    end
                end

                RELEASE_DB: begin
                    // A bounce back high parks in LONG so it can neither
                    // re-trigger a press nor produce a late long-press.
                    if (w_btn_s) begin
                        r_state <= LONG;
                        r_cnt   <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.oPress   = r_press;
    assign bus.oLong    = r_long;
    assign bus.oRelease = r_release;
    assign bus.oDrop    = r_drop;
    assign bus.oState   = r_state;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_btn_event_ctrl
//
// Directed scenarios followed by a randomized phase. A run-length reference
// model (consecutive-sample counts of the synchronised button, a debounced
// level and a last-accept timestamp) predicts every output each cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_btn_event_ctrl;

    localparam int D = 4;
    localparam int L = 20;
    localparam int C = 10;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PDB  = 3'd1;
    localparam logic [2:0] S_HELD = 3'd2;
    localparam logic [2:0] S_LONG = 3'd3;
    localparam logic [2:0] S_RDB  = 3'd4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    btn_event_ctrl_if bus ();

    btn_event_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .COOLDOWN_CYCLES (C)
    ) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         t_model  = 0;
    bit         m_sync0  = 0;
    bit         m_s      = 0;
    bit         m_db     = 0;
    bit         m_lblk   = 0;
    bit         m_hasacc = 0;
    int         m_ones   = 0;
    int         m_zeros  = 0;
    int         m_lastacc = 0;
    logic       m_press = 0, m_long = 0, m_rel = 0, m_drop = 0;
    logic [2:0] m_state = S_IDLE;

    always @(posedge clk) begin
        bit s_now;
        t_model++;
        m_press = 0; m_long = 0; m_rel = 0; m_drop = 0;
        if (!rst_n) begin
            m_sync0 = 0; m_s = 0; m_db = 0; m_lblk = 0; m_hasacc = 0;
            m_ones = 0; m_zeros = 0;
        end else begin
            s_now   = m_s;
            m_s     = m_sync0;
            m_sync0 = bus.iBtn;
            if (!m_db) begin
                if (s_now) begin
                    m_ones++;
                    if (m_ones == D + 1) begin
                        m_db = 1; m_zeros = 0; m_lblk = 0;
                        if (bus.iEnable && (!m_hasacc || (t_model - m_lastacc > C))) begin
                            m_press = 1; m_hasacc = 1; m_lastacc = t_model;
                        end else begin
                            m_drop = 1;
                        end
                    end
                end else begin
                    m_ones = 0;
                end
            end else begin
                if (s_now) begin
                    if (m_zeros > 0) begin
                        m_lblk = 1; m_zeros = 0;
                    end
                    m_ones++;
                    if (!m_lblk && m_ones == D + 1 + L) begin
                        m_long = 1; m_lblk = 1;
                    end
                end else begin
                    m_ones = 0;
                    m_zeros++;
                    if (m_zeros == D + 1) begin
                        m_rel = 1; m_db = 0; m_zeros = 0;
                    end
                end
            end
        end
        if (!m_db)            m_state = (m_ones > 0) ? S_PDB : S_IDLE;
        else if (m_zeros > 0) m_state = S_RDB;
        else if (m_lblk)      m_state = S_LONG;
        else                  m_state = S_HELD;
    end

    // ---------------- checking ----------------
    int n_chk = 0, n_pass = 0, n_fail = 0;
    int ec = 0;
    int n_press = 0, n_long = 0, n_rel = 0, n_drop = 0;
    int t_press = 0, t_long = 0, t_rel = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        ec++;
        @(negedge clk);
        chk("oPress",   32'(bus.oPress),   32'(m_press));
        chk("oLong",    32'(bus.oLong),    32'(m_long));
        chk("oRelease", 32'(bus.oRelease), 32'(m_rel));
        chk("oDrop",    32'(bus.oDrop),    32'(m_drop));
        chk("oState",   32'(bus.oState),   32'(m_state));
        if (bus.oPress   === 1'b1) begin n_press++; t_press = ec; end
        if (bus.oLong    === 1'b1) begin n_long++;  t_long  = ec; end
        if (bus.oRelease === 1'b1) begin n_rel++;   t_rel   = ec; end
        if (bus.oDrop    === 1'b1) begin n_drop++; end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_rel(input int hi, input int lo);
        bus.iBtn = 1'b1; ticks(hi);
        bus.iBtn = 1'b0; ticks(lo);
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.oPress, bus.oLong, bus.oRelease, bus.oDrop});
    endfunction

    initial begin
        int e0, r0, p0, l0, rl0, d0, run_left;
        bus.iBtn    = 1'b0;
        bus.iEnable = 1'b1;
        rst_n       = 1'b0;

        // reset state
        ticks(3);
        chk("reset_outs",  outs(), 32'd0);
        chk("reset_state", 32'(bus.oState), 32'(S_IDLE));
        rst_n = 1'b1;
        ticks(5);

        // clean press
        p0 = n_press; l0 = n_long; rl0 = n_rel;
        bus.iBtn = 1'b1; e0 = ec + 1; ticks(12);
        bus.iBtn = 1'b0; r0 = ec + 1; ticks(10);
        chk("clean_press_cnt", 32'(n_press - p0), 32'd1);
        chk("clean_press_lat", 32'(t_press - e0), 32'd6);
        chk("clean_long_cnt",  32'(n_long - l0),  32'd0);
        chk("clean_rel_cnt",   32'(n_rel - rl0),  32'd1);
        chk("clean_rel_lat",   32'(t_rel - r0),   32'd6);
        ticks(15);

        // press glitch: 3 high, 1 low, 2 high
        p0 = n_press; l0 = n_long; rl0 = n_rel; d0 = n_drop;
        bus.iBtn = 1'b1; ticks(3);
        bus.iBtn = 1'b0; ticks(1);
        bus.iBtn = 1'b1; ticks(2);
        bus.iBtn = 1'b0; ticks(10);
        chk("glitch_pulses", 32'((n_press - p0) + (n_long - l0) + (n_rel - rl0) + (n_drop - d0)), 32'd0);
        chk("glitch_state",  32'(bus.oState), 32'(S_IDLE));
        ticks(5);

        // bounce during release debounce parks in LONG
        p0 = n_press; l0 = n_long; rl0 = n_rel;
        bus.iBtn = 1'b1; ticks(10);
        bus.iBtn = 1'b0; ticks(2);
        bus.iBtn = 1'b1; ticks(6);
        chk("rbounce_state", 32'(bus.oState), 32'(S_LONG));
        ticks(30);
        bus.iBtn = 1'b0; ticks(10);
        chk("rbounce_press_cnt", 32'(n_press - p0), 32'd1);
        chk("rbounce_long_cnt",  32'(n_long - l0),  32'd0);
        chk("rbounce_rel_cnt",   32'(n_rel - rl0),  32'd1);
        ticks(15);

        // long hold
        p0 = n_press; l0 = n_long; rl0 = n_rel;
        bus.iBtn = 1'b1; e0 = ec + 1; ticks(40);
        bus.iBtn = 1'b0; r0 = ec + 1; ticks(10);
        chk("long_press_cnt", 32'(n_press - p0), 32'd1);
        chk("long_press_lat", 32'(t_press - e0), 32'd6);
        chk("long_cnt",       32'(n_long - l0),  32'd1);
        chk("long_lat",       32'(t_long - e0),  32'd26);
        chk("long_rel_cnt",   32'(n_rel - rl0),  32'd1);
        chk("long_rel_lat",   32'(t_rel - r0),   32'd6);
        ticks(15);

        // cooldown: accepts spaced 10 (drop), then 11 (press)
        p0 = n_press; d0 = n_drop;
        press_rel(5, 5);
        press_rel(5, 6);
        press_rel(5, 6);
        press_rel(5, 10);
        chk("cool_press_cnt", 32'(n_press - p0), 32'd3);
        chk("cool_drop_cnt",  32'(n_drop - d0),  32'd1);

        // disabled press drops without loading the cooldown
        p0 = n_press; d0 = n_drop;
        bus.iEnable = 1'b0;
        press_rel(5, 5);
        bus.iEnable = 1'b1;
        chk("en_drop_cnt", 32'(n_drop - d0), 32'd1);
        press_rel(5, 10);
        chk("en_press_cnt", 32'(n_press - p0), 32'd1);
        ticks(15);

        // reset while held
        bus.iBtn = 1'b1; ticks(10);
        rst_n = 1'b0; tick();
        chk("rst1_outs",  outs(), 32'd0);
        chk("rst1_state", 32'(bus.oState), 32'(S_IDLE));
        tick();
        chk("rst2_outs",  outs(), 32'd0);
        chk("rst2_state", 32'(bus.oState), 32'(S_IDLE));
        p0 = n_press;
        rst_n = 1'b1; e0 = ec + 1; ticks(8);
        chk("rst_repress_cnt", 32'(n_press - p0), 32'd1);
        chk("rst_repress_lat", 32'(t_press - e0), 32'd6);
        bus.iBtn = 1'b0; ticks(25);

        // fall on the press-debounce threshold cycle
        p0 = n_press; d0 = n_drop;
        bus.iBtn = 1'b1; ticks(4);
        bus.iBtn = 1'b0; ticks(3);
        chk("bnd_pdb_state", 32'(bus.oState), 32'(S_IDLE));
        chk("bnd_pdb_pulse", 32'((n_press - p0) + (n_drop - d0)), 32'd0);
        ticks(15);

        // fall on the long threshold cycle
        p0 = n_press; l0 = n_long; rl0 = n_rel;
        bus.iBtn = 1'b1; ticks(24);
        bus.iBtn = 1'b0; ticks(3);
        chk("bnd_held_state", 32'(bus.oState), 32'(S_RDB));
        chk("bnd_held_long",  32'(n_long - l0), 32'd0);
        ticks(10);
        chk("bnd_held_rel",   32'(n_rel - rl0),  32'd1);
        chk("bnd_held_press", 32'(n_press - p0), 32'd1);
        ticks(15);

        // randomized phase
        run_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                bus.iBtn = ~bus.iBtn;
                run_left = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 8))
                                                       : int'($urandom_range(1, 40));
            end
            run_left--;
            bus.iEnable = ($urandom_range(0, 3) != 0);
            rst_n       = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1'b1;
        bus.iBtn = 1'b0;
        ticks(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
